// File: rtl/soc_bus_fabric_pkg.sv
// Shared types and default memory map for the SoC bus fabric.
// Holds the FSM state encoding, default slave map and error read data.
package soc_bus_fabric_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_SLAVES_DEF = 3;

    // Slave 0 = memory, slave 1 = UART, slave 2 = peripheral window
    localparam logic [NUM_SLAVES_DEF*ADDR_WIDTH_DEF-1:0] SLV_BASE_DEF =
        {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NUM_SLAVES_DEF*ADDR_WIDTH_DEF-1:0] SLV_MASK_DEF =
        {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000};

    localparam logic [DATA_WIDTH_DEF-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_bus_fabric_bus_addr_decoder.sv
// Combinational address decoder: reports whether any slave window matches
// and the lowest matching slave index.
module bus_addr_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_WIDTH  = 2
) (
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] mask,
    output logic                             hit,
    output logic [SEL_WIDTH-1:0]             sel
);

    // Scan from the top so the lowest matching index is the last one written
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & mask[i*ADDR_WIDTH +: ADDR_WIDTH]) == base[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit = 1'b1;
                sel = SEL_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/soc_bus_fabric.sv
// Address-decoding interconnect between the CPU master and NUM_SLAVES slaves,
// with one outstanding transaction, a slave timeout and error responses.
module soc_bus_fabric
    import soc_bus_fabric_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_SLAVES = NUM_SLAVES_DEF,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = SLV_BASE_DEF,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = SLV_MASK_DEF,
    parameter int TIMEOUT = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            m_addr,
    input  logic [DATA_WIDTH-1:0]            m_wrt_data,
    input  logic                             m_we,
    input  logic                             m_req_valid,
    output logic [DATA_WIDTH-1:0]            m_rd_data,
    output logic                             m_data_valid,
    output logic                             m_bus_err,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wrt_data,
    output logic                             s_we,
    output logic [NUM_SLAVES-1:0]            s_req_valid,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rd_data,
    input  logic [NUM_SLAVES-1:0]            s_data_valid
);

    localparam int SEL_WIDTH = sel_width(NUM_SLAVES);
    localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t                state;
    logic [SEL_WIDTH-1:0]  sel;
    logic [CNT_WIDTH-1:0]  count;
    logic                  dec_hit;
    logic [SEL_WIDTH-1:0]  dec_sel;
    logic [DATA_WIDTH-1:0] sel_rd_data;
    logic                  sel_valid;

    bus_addr_decoder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_SLAVES(NUM_SLAVES),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_decoder (
        .addr(m_addr),
        .base(SLV_BASE),
        .mask(SLV_MASK),
        .hit (dec_hit),
        .sel (dec_sel)
    );

    // Only the selected slave's response is visible; others are ignored
    always_comb begin
        sel_rd_data = s_rd_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        sel_valid   = s_data_valid[sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sel          <= '0;
            count        <= '0;
            s_req_valid  <= '0;
            s_addr       <= '0;
            s_wrt_data   <= '0;
            s_we         <= 1'b0;
            m_rd_data    <= '0;
            m_data_valid <= 1'b0;
            m_bus_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_req_valid) begin
                        if (dec_hit) begin
                            s_addr      <= m_addr;
                            s_wrt_data  <= m_wrt_data;
                            s_we        <= m_we;
                            sel         <= dec_sel;
                            count       <= '0;
                            s_req_valid <= NUM_SLAVES'(1) << dec_sel;
                            state       <= BUSY;
                        end else begin
                            m_rd_data    <= ERR_DATA;
                            m_bus_err    <= 1'b1;
                            m_data_valid <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end
                BUSY: begin
                    count <= count + 1'b1;
                    // A response arriving on the last allowed cycle still wins
                    if (sel_valid) begin
                        m_rd_data    <= sel_rd_data;
                        m_bus_err    <= 1'b0;
                        m_data_valid <= 1'b1;
                        s_req_valid  <= '0;
                        state        <= RESP;
                    end else if (count == CNT_LAST) begin
                        m_rd_data    <= ERR_DATA;
                        m_bus_err    <= 1'b1;
                        m_data_valid <= 1'b1;
                        s_req_valid  <= '0;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    m_data_valid <= 1'b0;
                    m_bus_err    <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    s_req_valid  <= '0;
                    m_data_valid <= 1'b0;
                    m_bus_err    <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Directed, scoreboard-based bench for soc_bus_fabric using the default
// three-slave map and a short slave timeout of 8 cycles.
module tb_soc_bus_fabric;
    import soc_bus_fabric_pkg::*;

    localparam int NS = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wrt_data;
    logic             m_we;
    logic             m_req_valid;
    logic [DW-1:0]    m_rd_data;
    logic             m_data_valid;
    logic             m_bus_err;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_wrt_data;
    logic             s_we;
    logic [NS-1:0]    s_req_valid;
    logic [NS*DW-1:0] s_rd_data;
    logic [NS-1:0]    s_data_valid;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    soc_bus_fabric #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NUM_SLAVES(NS),
        .SLV_BASE  ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLV_MASK  ({32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000}),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_addr      (m_addr),
        .m_wrt_data  (m_wrt_data),
        .m_we        (m_we),
        .m_req_valid (m_req_valid),
        .m_rd_data   (m_rd_data),
        .m_data_valid(m_data_valid),
        .m_bus_err   (m_bus_err),
        .s_addr      (s_addr),
        .s_wrt_data  (s_wrt_data),
        .s_we        (s_we),
        .s_req_valid (s_req_valid),
        .s_rd_data   (s_rd_data),
        .s_data_valid(s_data_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to its response. exp_sel=0 means unmapped,
    // resp_cycle=0 means the slave never answers; cycles count BUSY cycles from 1.
    task automatic run_txn(input string tag, input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wdata, input logic [NS-1:0] exp_sel,
                           input int resp_cycle, input int resp_slave, input logic [DW-1:0] rdata,
                           input int spur_cycle, input int exp_latency);
        exp_t e;
        exp_t got_e;
        int   cyc;
        bit   got;
        if (exp_sel == '0 || resp_cycle == 0) e = '{data: 32'hDEAD_BEEF, err: 1'b1};
        else                                  e = '{data: rdata, err: 1'b0};
        exp_q.push_back(e);
        m_req_valid = 1'b1;
        m_addr      = addr;
        m_we        = we;
        m_wrt_data  = wdata;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            s_data_valid = '0;
            if (cyc >= 1 && cyc == resp_cycle) begin
                s_data_valid[resp_slave]      = 1'b1;
                s_rd_data[resp_slave*DW +: DW] = rdata;
            end
            if (cyc >= 1 && cyc == spur_cycle) begin
                s_data_valid[1]     = 1'b1;
                s_rd_data[DW +: DW] = 32'hBAD0_0001;
            end
            tick();
            cyc++;
            s_data_valid = '0;
            if (m_data_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                check_output({tag, ".s_req_valid"}, 64'(s_req_valid), 64'(exp_sel));
                if (cyc == 1 && exp_sel != '0) begin
                    check_output({tag, ".s_addr"}, 64'(s_addr), 64'(addr));
                    check_output({tag, ".s_we"}, 64'(s_we), 64'(we));
                    check_output({tag, ".s_wrt_data"}, 64'(s_wrt_data), 64'(wdata));
                end
            end
        end
        check_output({tag, ".responded"}, 64'(got), 64'(1));
        check_output({tag, ".latency"}, 64'(cyc), 64'(exp_latency));
        got_e = '{data: '0, err: 1'b0};
        if (exp_q.size() > 0) got_e = exp_q.pop_front();
        check_output({tag, ".rd_data"}, 64'(m_rd_data), 64'(got_e.data));
        check_output({tag, ".bus_err"}, 64'(m_bus_err), 64'(got_e.err));
        check_output({tag, ".resp_s_req"}, 64'(s_req_valid), 64'(0));
        tick();
        check_output({tag, ".pulse_end"}, 64'(m_data_valid), 64'(0));
        m_req_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        m_addr       = '0;
        m_wrt_data   = '0;
        m_we         = 1'b0;
        m_req_valid  = 1'b0;
        s_rd_data    = '0;
        s_data_valid = '0;
        tick();
        tick();
        check_output("rst.s_req_valid", 64'(s_req_valid), 64'(0));
        check_output("rst.m_data_valid", 64'(m_data_valid), 64'(0));
        check_output("rst.m_bus_err", 64'(m_bus_err), 64'(0));
        check_output("rst.m_rd_data", 64'(m_rd_data), 64'(0));
        check_output("rst.s_addr", 64'(s_addr), 64'(0));
        reset = 1'b0;
        tick();

        // Read slave 0, answer in the 3rd BUSY cycle
        run_txn("rd_s0", 32'h0000_0040, 1'b0, 32'h0, 3'b001, 3, 0, 32'h1234_5678, 0, 4);
        tick();
        // Write to the UART, acknowledged in the first BUSY cycle
        run_txn("wr_uart", 32'h1000_0004, 1'b1, 32'h0000_0041, 3'b010, 1, 1, 32'h0000_0000, 0, 2);
        tick();
        // Unmapped address
        run_txn("unmapped", 32'h3000_0000, 1'b0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 1);
        tick();
        // Slave 2 never answers
        run_txn("timeout", 32'h2000_0100, 1'b0, 32'h0, 3'b100, 0, 2, 32'h0, 0, TO + 1);
        tick();
        // Spurious slave 1 pulse while slave 0 is selected
        run_txn("spurious", 32'h0000_0044, 1'b0, 32'h0, 3'b001, 3, 0, 32'hCAFE_0044, 1, 4);
        tick();
        // Slave 0 answers on the last BUSY cycle, same cycle the timeout would fire
        run_txn("race", 32'h0000_0200, 1'b0, 32'h0, 3'b001, TO, 0, 32'hAAAA_5555, 0, TO + 1);
        tick();

        // Reset two cycles into a slave 0 read
        m_req_valid = 1'b1;
        m_addr      = 32'h0000_0080;
        m_we        = 1'b0;
        tick();
        tick();
        check_output("midrst.busy_s_req", 64'(s_req_valid), 64'(3'b001));
        reset                = 1'b1;
        s_data_valid[0]      = 1'b1;
        s_rd_data[0 +: DW]   = 32'h5555_0080;
        tick();
        check_output("midrst.s_req_dropped", 64'(s_req_valid), 64'(0));
        check_output("midrst.no_valid", 64'(m_data_valid), 64'(0));
        reset        = 1'b0;
        m_req_valid  = 1'b0;
        s_data_valid = '0;
        tick();
        check_output("midrst.no_valid_after", 64'(m_data_valid), 64'(0));
        tick();
        check_output("midrst.still_quiet", 64'(m_data_valid), 64'(0));

        // Back-to-back reads: second request arrives in the IDLE cycle after RESP
        run_txn("b2b_a", 32'h0000_0010, 1'b0, 32'h0, 3'b001, 1, 0, 32'h0101_0010, 0, 2);
        run_txn("b2b_b", 32'h1000_0000, 1'b0, 32'h0, 3'b010, 2, 1, 32'h0202_1000, 0, 3);
        tick();
        check_output("scoreboard.empty", 64'(exp_q.size()), 64'(0));

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/soc_bus_fabric.md
Name: soc_bus_fabric

Overview:
- Parametrised address-decoding interconnect between the single CPU bus master (`cpu_top`) and NUM_SLAVES bus slaves (memory, UART, future peripherals).
- Replaces the direct shared-wire hookup at SoC top.
- Uses the existing protocol: req_valid / we / addr / wrt_data out, rd_data / data_valid back.
- Adds per-slave address decode, one-outstanding-transaction tracking, response muxing, a slave-timeout watchdog and error responses for unmapped or hung accesses.

Parameters:
- ADDR_WIDTH, 32, master/slave address width.
- DATA_WIDTH, 32, data bus width.
- NUM_SLAVES, 3, number of slave ports (>=1).
- SLV_BASE, {32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flattened NUM_SLAVES*ADDR_WIDTH base addresses; slave i in slice i.
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_0000}, flattened match masks; slave i hits when (addr & MASK_i) == BASE_i.
- TIMEOUT, 255, max cycles waiting for slave data_valid (>=1).
- ERR_DATA, 32'hDEAD_BEEF, rd_data returned on an error response.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m_addr  in  ADDR_WIDTH  master address.
- m_wrt_data  in  DATA_WIDTH  master write data.
- m_we  in  1  1=write, 0=read.
- m_req_valid  in  1  master request; held stable until m_data_valid.
- m_rd_data  out  DATA_WIDTH  response data, registered.
- m_data_valid  out  1  one-cycle response pulse, registered.
- m_bus_err  out  1  qualifies m_data_valid as error response.
- s_addr  out  ADDR_WIDTH  latched address, common to all slaves.
- s_wrt_data  out  DATA_WIDTH  latched write data, common.
- s_we  out  1  latched we, common.
- s_req_valid  out  NUM_SLAVES  one-hot request; only the selected bit is high.
- s_rd_data  in  NUM_SLAVES*DATA_WIDTH  flattened slave read data.
- s_data_valid  in  NUM_SLAVES  slave response pulses.

Behaviour:
- Reset values:
  - State IDLE.
  - s_req_valid=0; m_data_valid=0; m_bus_err=0; m_rd_data=0.
  - s_addr / s_wrt_data / s_we = 0.
  - Timeout counter 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If m_req_valid=1 and some slave hits: latch addr/we/wrt_data, latch sel = lowest hitting index, counter=0, go BUSY.
  - If m_req_valid=1 and no hit: latch m_rd_data=ERR_DATA, err=1, go RESP.
  - Otherwise stay in IDLE.
- BUSY:
  - s_req_valid[sel]=1; all other bits 0.
  - Counter increments each cycle.
  - If s_data_valid[sel]: capture s_rd_data slice sel into m_rd_data, err=0, go RESP.
  - Else if counter == TIMEOUT-1: m_rd_data=ERR_DATA, err=1, go RESP.
  - s_data_valid from any non-selected slave is ignored.
  - If data_valid and timeout coincide, data_valid wins.
- RESP:
  - m_data_valid=1 and m_bus_err=err for exactly one cycle.
  - s_req_valid=0.
  - Next state IDLE unconditionally.
  - The master drops or replaces its request in the cycle after m_data_valid, so no double accept occurs.
- Latency:
  - Hit: m_data_valid 1 cycle after the cycle s_data_valid is seen; minimum 2 cycles from the IDLE accept edge (slave responding in its first BUSY cycle).
  - Miss: m_data_valid 1 cycle after accept.
  - Timeout: m_data_valid TIMEOUT+1 cycles after accept.
- Writes: same flow; the slave's data_valid is the write acknowledge, and m_rd_data takes the slave's rd_data (don't-care to master).
- Overlapping masks: the lowest index has priority.
- Reset mid-transaction: immediate return to IDLE. The pending response is discarded; no m_data_valid is issued for it, and s_req_valid drops in the same cycle reset is sampled.
- Back-to-back: a new request sampled in IDLE in the cycle after RESP is accepted normally.
- Counter width: $clog2(TIMEOUT+1); no wrap, since it is cleared on each accept.

Decomposition:
- Shared package/header (system_param.vh): ADDR_WIDTH / DATA_WIDTH defines, FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), default SLV_BASE / SLV_MASK map, ERR_DATA.
- Natural sub-module: bus_addr_decoder. Purely combinational; takes addr plus the BASE/MASK vectors and outputs hit and a sel index using a lowest-index priority encoder.
- The FSM, timeout counter and response mux stay in soc_bus_fabric.

Test Plan:
- Read slave0: m_addr=0x0000_0040 read; slave0 answers data_valid with 0x1234_5678 in 3rd BUSY cycle -> s_req_valid=3'b001 only; m_data_valid one pulse with m_rd_data=0x1234_5678, m_bus_err=0.
- Write UART: m_addr=0x1000_0004, we=1, wrt_data=0x41 -> s_req_valid=3'b010, s_we=1, s_wrt_data=0x41; ack -> m_data_valid=1, m_bus_err=0.
- Unmapped: m_addr=0x3000_0000 -> no s_req_valid bit set; m_data_valid=1 with m_bus_err=1 and m_rd_data=0xDEAD_BEEF exactly 1 cycle after accept.
- Timeout: TIMEOUT=8, slave2 never responds -> s_req_valid[2] high 8 cycles then low; m_data_valid with m_bus_err=1 and m_rd_data=0xDEAD_BEEF at cycle 9.
- Race and spurious valid: slave1 pulses data_valid while slave0 is selected -> ignored. Separately with TIMEOUT=8, slave0 responds 0xAAAA_5555 in the final BUSY cycle (counter=7) -> m_bus_err=0, m_rd_data=0xAAAA_5555.
- Reset mid-BUSY: assert reset 2 cycles into a slave0 read -> s_req_valid=0 next cycle, no m_data_valid. After deassert, a back-to-back pair of reads (0x0000_0010, then 0x1000_0000) completes in order.
